// File: rtl/instruction_cache_controller.sv
// Direct-mapped instruction cache with a single-block refill sequencer.
// Fetches hit combinationally; misses stall via busywait while one block is read from memory.
module instruction_cache_controller #(
  parameter int unsigned NUM_SETS = 8,
  parameter int unsigned INDEX_W  = 3,
  parameter int unsigned TAG_W    = 25
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     cpu_read,
  input  logic [31:0]              cpu_address,
  output logic [31:0]              cpu_readdata,
  output logic                     busywait,
  output logic                     mem_read,
  output logic [TAG_W+INDEX_W-1:0] mem_address,
  input  logic [127:0]             mem_readdata,
  input  logic                     mem_busywait,
  output logic [31:0]              hit_count,
  output logic [31:0]              miss_count
);

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned BLOCK_W = 128;
  localparam int unsigned WORD_W  = 32;

  typedef enum logic [1:0] {IDLE, MEM_READ, FILL} state_t;

  state_t state, state_nxt;

  logic [NUM_SETS-1:0] valid;
  logic [TAG_W-1:0]    tag_store  [NUM_SETS];
  logic [BLOCK_W-1:0]  data_store [NUM_SETS];
  logic [BLOCK_W-1:0]  fill_buf;
  logic [WORD_W-1:0]   last_data;

  logic [INDEX_W-1:0] cpu_index;
  logic [TAG_W-1:0]   cpu_tag;
  logic [1:0]         word_sel;
  logic [INDEX_W-1:0] fill_index;
  logic [TAG_W-1:0]   fill_tag;
  logic [WORD_W-1:0]  sel_word;
  logic               hit;
  logic               unused_addr_bits;

  logic busy_c, start_miss, capture, do_fill, count_hit;

  assign cpu_index        = cpu_address[4 +: INDEX_W];
  assign cpu_tag          = cpu_address[ADDR_W-1 -: TAG_W];
  assign word_sel         = cpu_address[3:2];
  assign unused_addr_bits = ^cpu_address[1:0];
  assign fill_index       = mem_address[INDEX_W-1:0];
  assign fill_tag         = mem_address[INDEX_W +: TAG_W];

  assign hit      = cpu_read & valid[cpu_index] & (tag_store[cpu_index] == cpu_tag);
  assign sel_word = data_store[cpu_index][{word_sel, 5'b00000} +: WORD_W];

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state and control decode
  always_comb begin
    state_nxt  = state;
    busy_c     = 1'b0;
    start_miss = 1'b0;
    capture    = 1'b0;
    do_fill    = 1'b0;
    count_hit  = 1'b0;
    case (state)
      IDLE: begin
        if (hit) begin
          count_hit = 1'b1;
        end else if (cpu_read) begin
          busy_c     = 1'b1;
          start_miss = 1'b1;
          state_nxt  = MEM_READ;
        end
      end
      MEM_READ: begin
        busy_c = 1'b1;
        if (!mem_busywait) begin
          capture   = 1'b1;
          state_nxt = FILL;
        end
      end
      FILL: begin
        busy_c    = 1'b1;
        do_fill   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busywait     = busy_c & ~reset;
  assign cpu_readdata = reset ? '0 : (count_hit ? sel_word : last_data);

  // Control registers, counters and refill buffer
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid       <= '0;
      mem_read    <= 1'b0;
      mem_address <= '0;
      hit_count   <= '0;
      miss_count  <= '0;
      last_data   <= '0;
      fill_buf    <= '0;
    end else begin
      if (count_hit) begin
        hit_count <= hit_count + 32'd1;
        last_data <= sel_word;
      end
      if (start_miss) begin
        mem_address <= {cpu_tag, cpu_index};
        mem_read    <= 1'b1;
        miss_count  <= miss_count + 32'd1;
      end
      if (capture) begin
        fill_buf <= mem_readdata;
        mem_read <= 1'b0;
      end
      if (do_fill) valid[fill_index] <= 1'b1;
    end
  end

  // Line storage; only written on the fill cycle, which reset cancels
  always_ff @(posedge clock) begin
    if (do_fill && !reset) begin
      data_store[fill_index] <= fill_buf;
      tag_store[fill_index]  <= fill_tag;
    end
  end

endmodule
